cpec_decoder: RTL

- Receiver-side counterpart of the CPEC packer.
- Accepts one packed 40-bit group of four samples with its Bits_req, ecgidx, size and group-skip control.
- Unpacks the four fields and restores full-width signed samples: sign-extends two's-complement fields, and re-applies sign bits to sign-magnitude fields.
- Emits the samples one per beat on a valid/ready stream toward the ECG reconstruction path.

---
 rtl/cpec_decoder.sv | 134 +++++++++++++
 1 files changed

// File: rtl/cpec_decoder.sv
// CPEC receiver: unpacks a 40-bit group of four fields and streams the
// restored J-bit signed samples one per beat on a valid/ready interface.
module cpec_decoder #(
    parameter int unsigned J = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [39:0]  CPEC_encoded,
    input  logic [5:0]   size_CPEC_encoded,
    input  logic [3:0]   Bits_req,
    input  logic [1:0]   ecgidx,
    input  logic [3:0]   sign_bits,
    input  logic         Group_skip_flag,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [J-1:0] sample_out,
    output logic [1:0]   sample_idx,
    output logic         last,
    output logic         err
);

    localparam int unsigned W     = 40;
    localparam logic [3:0]  B_MIN = 4'd3;
    localparam logic [3:0]  B_MAX = 4'(J);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t         state;
    logic [W-1:0]   word_q;
    logic [3:0]     b_q;
    logic [1:0]     ecg_q;
    logic [3:0]     signs_q;
    logic           skip_q;
    logic           group_ok_c;

    // Extract field k (0 = most significant) and restore it to a J-bit signed value.
    function automatic logic [J-1:0] decode(
        input logic [W-1:0] word,
        input logic [3:0]   b,
        input logic [1:0]   ecg,
        input logic [3:0]   signs,
        input logic         skip,
        input logic [1:0]   k
    );
        logic [5:0]   shamt;
        logic [W-1:0] mask;
        logic [W-1:0] f;
        logic [J-1:0] m;
        logic         neg;
        shamt = 6'(b) * (6'd3 - 6'(k));
        mask  = (W'(1) << b) - W'(1);
        f     = (word >> shamt) & mask;
        m     = f[J-1:0];
        neg   = signs[2'd3 - k];
        if (skip) begin
            decode = '0;
        end else if (ecg == 2'd3) begin
            if (f[6'(b) - 6'd1]) begin
                f = f | ~mask;
            end
            decode = f[J-1:0];
        end else begin
            // A negative zero collapses to 0 because m == 0 skips the negate.
            decode = (neg && (m != '0)) ? (~m + J'(1)) : m;
        end
    endfunction

    assign group_ok_c = Group_skip_flag ||
                        ((Bits_req >= B_MIN) && (Bits_req <= B_MAX) &&
                         (size_CPEC_encoded == 6'(Bits_req) * 6'd4));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            sample_out <= '0;
            sample_idx <= '0;
            last       <= 1'b0;
            err        <= 1'b0;
            word_q     <= '0;
            b_q        <= '0;
            ecg_q      <= '0;
            signs_q    <= '0;
            skip_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    err      <= 1'b0;
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        word_q  <= CPEC_encoded;
                        b_q     <= Bits_req;
                        ecg_q   <= ecgidx;
                        signs_q <= sign_bits;
                        skip_q  <= Group_skip_flag;
                        if (group_ok_c) begin
                            // First sample decoded straight from the inputs for 1-cycle latency.
                            state      <= EMIT;
                            in_ready   <= 1'b0;
                            out_valid  <= 1'b1;
                            sample_idx <= 2'd0;
                            last       <= 1'b0;
                            sample_out <= decode(CPEC_encoded, Bits_req, ecgidx,
                                                 sign_bits, Group_skip_flag, 2'd0);
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        if (sample_idx == 2'd3) begin
                            state      <= IDLE;
                            in_ready   <= 1'b1;
                            out_valid  <= 1'b0;
                            last       <= 1'b0;
                            sample_idx <= 2'd0;
                            sample_out <= '0;
                        end else begin
                            sample_idx <= sample_idx + 2'd1;
                            last       <= (sample_idx == 2'd2);
                            sample_out <= decode(word_q, b_q, ecg_q, signs_q, skip_q,
                                                 sample_idx + 2'd1);
                        end
                    end
                end
            endcase
        end
    end

endmodule
